// File: rtl/count_checker.sv
// count_checker: locks onto a +/-1 modulo-2^WIDTH count stream and flags/counts sequence breaks once locked.
// Single-cycle latency, all outputs registered; optional err_clr input under CHECKER_ERR_CLR_EN.
module count_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 2,
    parameter int ERRW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
`ifdef CHECKER_ERR_CLR_EN
    input  logic             err_clr,
`endif
    output logic             locked,
    output logic             err_pulse,
    output logic [ERRW-1:0]  err_cnt,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACQ  = 2'b01,
        ST_LOCK = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [3:0]       run_q, run_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] next_val;
    logic [3:0]       run_inc;
    logic             hit;
    logic             clr;

    // Prediction for the following sample always uses the dir that arrives with this din.
    assign next_val = dir ? (din - WIDTH'(1)) : (din + WIDTH'(1));
    assign hit      = (din == expected_q);
    assign run_inc  = run_q + 4'd1;

`ifdef CHECKER_ERR_CLR_EN
    assign clr = err_clr;
`else
    assign clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: state_d = ST_ACQ;
                ST_ACQ:  if (hit && (run_inc == LOCK_RUN)) state_d = ST_LOCK;
                ST_LOCK: if (!hit) state_d = ST_ERR;
                ST_ERR:  if (hit) state_d = (LOCK_RUN == 4'd2) ? ST_LOCK : ST_ACQ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        expected_d  = expected_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (enable) begin
            expected_d = next_val;
            case (state_q)
                ST_IDLE: run_d = 4'd1;
                ST_ACQ:  run_d = hit ? run_inc : 4'd1;
                ST_LOCK: begin
                    if (!hit) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRW'(1);
                    end
                end
                ST_ERR:  if (hit) run_d = 4'd2;
                default: run_d = run_q;
            endcase
        end
        // A clear on the same edge as a counted mismatch leaves zero but keeps the pulse.
        if (clr) err_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            expected_q  <= '0;
            run_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            expected_q  <= expected_d;
            run_q       <= run_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = (state_q == ST_LOCK);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign expected  = expected_q;
    assign state     = state_q;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed vector table, randomized run against a reference model,
// saturation with a narrow error counter, and err_clr priority when CHECKER_ERR_CLR_EN is set.
module tb_count_checker;

    localparam int LOCK_CNT = 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] din;
    logic       dir;
`ifdef CHECKER_ERR_CLR_EN
    logic       err_clr;
`endif

    logic       locked8, pulse8;
    logic [7:0] cnt8, exp8;
    logic [1:0] st8;
    logic       lockeds, pulses;
    logic [1:0] cnts;
    logic [7:0] exps;
    logic [1:0] sts;

    count_checker #(.WIDTH(8), .LOCK_CNT(LOCK_CNT), .ERRW(8)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .din(din), .dir(dir),
`ifdef CHECKER_ERR_CLR_EN
        .err_clr(err_clr),
`endif
        .locked(locked8), .err_pulse(pulse8), .err_cnt(cnt8), .expected(exp8), .state(st8)
    );

    count_checker #(.WIDTH(8), .LOCK_CNT(LOCK_CNT), .ERRW(2)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .din(din), .dir(dir),
`ifdef CHECKER_ERR_CLR_EN
        .err_clr(err_clr),
`endif
        .locked(lockeds), .err_pulse(pulses), .err_cnt(cnts), .expected(exps), .state(sts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase 0..3 matches the state codes; the error total is unbounded and
    // clipped to each instance's counter width at compare time.
    int m_st    = 0;
    int m_exp   = 0;
    int m_run   = 0;
    int m_cnt   = 0;
    bit m_pulse = 0;

    task automatic model_step(input bit r, input bit e, input int d, input bit dr, input bit c);
        int nxt;
        bit hit;
        if (!r) begin
            m_st = 0; m_exp = 0; m_run = 0; m_cnt = 0; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        if (e) begin
            hit = (d == m_exp);
            nxt = dr ? (d + 255) % 256 : (d + 1) % 256;
            case (m_st)
                0: begin m_st = 1; m_run = 1; end
                1: begin
                    if (hit) begin
                        m_run = m_run + 1;
                        if (m_run >= LOCK_CNT) m_st = 2;
                    end else begin
                        m_run = 1;
                    end
                end
                2: if (!hit) begin m_pulse = 1; m_cnt = m_cnt + 1; m_st = 3; end
                default: if (hit) begin m_run = 2; m_st = (m_run >= LOCK_CNT) ? 2 : 1; end
            endcase
            m_exp = nxt;
        end
        if (c) m_cnt = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    task automatic check_all(input string tag, input int st, input int ex, input int lk,
                             input int pu, input int cnt);
        chk({tag, " state"},       32'(st8),      32'(st));
        chk({tag, " expected"},    32'(exp8),     32'(ex));
        chk({tag, " locked"},      32'(locked8),  32'(lk));
        chk({tag, " err_pulse"},   32'(pulse8),   32'(pu));
        chk({tag, " err_cnt"},     32'(cnt8),     32'((cnt > 255) ? 255 : cnt));
        chk({tag, " sat state"},   32'(sts),      32'(st));
        chk({tag, " sat expected"},32'(exps),     32'(ex));
        chk({tag, " sat locked"},  32'(lockeds),  32'(lk));
        chk({tag, " sat pulse"},   32'(pulses),   32'(pu));
        chk({tag, " sat err_cnt"}, 32'(cnts),     32'((cnt > 3) ? 3 : cnt));
    endtask

    task automatic drive(input bit r, input bit e, input int d, input bit dr, input bit c);
        reset  = r;
        enable = e;
        din    = d[7:0];
        dir    = dr;
`ifdef CHECKER_ERR_CLR_EN
        err_clr = c;
`endif
        @(posedge clk);
        model_step(r, e, d, dr, c);
        #1;
    endtask

    typedef struct {
        bit   rst_n;
        bit   en;
        int   din;
        bit   dir;
        int   st;
        int   ex;
        int   lk;
        int   pu;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit e, input int d, input bit dr,
                       input int st, input int ex, input int lk, input int pu, input int cnt);
        vec_t v;
        v = '{r, e, d, dr, st, ex, lk, pu, cnt};
        tbl.push_back(v);
    endtask

    initial begin
        int pulse_seen;
        reset = 1'b0; enable = 1'b0; din = 8'h00; dir = 1'b0;
`ifdef CHECKER_ERR_CLR_EN
        err_clr = 1'b0;
`endif
        //   rst en din   dir  st  exp   lk pu cnt
        add(0, 1, 8'h5A, 0,   0, 8'h00, 0, 0, 0);   // reset wins over enable
        add(0, 1, 8'hC3, 1,   0, 8'h00, 0, 0, 0);
        add(1, 1, 8'hFD, 0,   1, 8'hFE, 0, 0, 0);   // up count through the wrap
        add(1, 1, 8'hFE, 0,   2, 8'hFF, 1, 0, 0);
        add(1, 1, 8'hFF, 0,   2, 8'h00, 1, 0, 0);
        add(1, 1, 8'h00, 0,   2, 8'h01, 1, 0, 0);
        add(1, 1, 8'h01, 0,   2, 8'h02, 1, 0, 0);
        add(0, 1, 8'h00, 0,   0, 8'h00, 0, 0, 0);   // down count through the wrap
        add(1, 1, 8'h01, 1,   1, 8'h00, 0, 0, 0);
        add(1, 1, 8'h00, 1,   2, 8'hFF, 1, 0, 0);
        add(1, 1, 8'hFF, 1,   2, 8'hFE, 1, 0, 0);
        add(0, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0);   // sequence break while locked
        add(1, 1, 8'h0F, 0,   1, 8'h10, 0, 0, 0);
        add(1, 1, 8'h10, 0,   2, 8'h11, 1, 0, 0);
        add(1, 1, 8'h20, 0,   3, 8'h21, 0, 1, 1);
        add(1, 1, 8'h21, 0,   2, 8'h22, 1, 0, 1);
        for (int i = 0; i < 5; i++)
            add(1, 0, 8'h77, 1, 2, 8'h22, 1, 0, 1); // enable gap holds everything
        add(1, 1, 8'h22, 0,   2, 8'h23, 1, 0, 1);
        add(1, 1, 8'h23, 1,   2, 8'h22, 1, 0, 1);   // dir flip: compare uses old prediction
        add(1, 1, 8'h22, 1,   2, 8'h21, 1, 0, 1);
        add(1, 1, 8'h50, 1,   3, 8'h4F, 0, 1, 2);
        add(1, 1, 8'h60, 1,   3, 8'h5F, 0, 0, 2);   // repeated mismatch in ERR: no pulse
        add(1, 0, 8'h00, 0,   3, 8'h5F, 0, 0, 2);
        add(1, 1, 8'h5F, 1,   2, 8'h5E, 1, 0, 2);
        add(0, 1, 8'h10, 0,   0, 8'h00, 0, 0, 0);   // reset mid-stream clears history
        add(1, 1, 8'h10, 0,   1, 8'h11, 0, 0, 0);
        add(1, 1, 8'h30, 0,   1, 8'h31, 0, 0, 0);   // ACQ mismatch is not an error
        add(1, 1, 8'h31, 0,   2, 8'h32, 1, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].en, tbl[i].din, tbl[i].dir, 1'b0);
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].ex, tbl[i].lk, tbl[i].pu,
                      tbl[i].cnt);
        end

        // Randomized stream, mostly on-sequence with occasional breaks, gaps and resets.
        begin
            bit rdir;
            rdir = 1'b0;
            drive(0, 0, 0, 0, 0);
            for (int i = 0; i < 3000; i++) begin
                int  d;
                bit  e, r, c;
                if ($urandom_range(0, 99) < 5) rdir = ~rdir;
                d = ($urandom_range(0, 99) < 85) ? m_exp : int'($urandom_range(0, 255));
                e = ($urandom_range(0, 99) < 85);
                r = ($urandom_range(0, 999) >= 5);
                c = 1'b0;
`ifdef CHECKER_ERR_CLR_EN
                c = ($urandom_range(0, 99) < 3);
`endif
                drive(r, e, d, rdir, c);
                check_all($sformatf("rnd%0d", i), m_st, m_exp, (m_st == 2) ? 1 : 0,
                          int'(m_pulse), m_cnt);
            end
        end

        // Five lock/break cycles: 2-bit counter sticks at 3, every break still pulses.
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 8'h00, 0, 0);
        pulse_seen = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, m_exp, 0, 0);
            check_all($sformatf("sat%0d lock", k), m_st, m_exp, 1, 0, m_cnt);
            drive(1, 1, (m_exp + 128) % 256, 0, 0);
            if (pulses === 1'b1) pulse_seen++;
            check_all($sformatf("sat%0d break", k), m_st, m_exp, 0, 1, m_cnt);
        end
        chk("sat err_cnt held", 32'(cnts), 32'd3);
        chk("sat pulse total", 32'(pulse_seen), 32'd5);
        chk("wide err_cnt total", 32'(cnt8), 32'd5);

`ifdef CHECKER_ERR_CLR_EN
        // Clear on the same edge as a LOCK mismatch: count goes to zero, pulse still fires.
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 8'h40, 0, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, m_exp, 0, 0);
            drive(1, 1, (m_exp + 128) % 256, 0, 0);
        end
        chk("clr setup err_cnt", 32'(cnt8), 32'd2);
        drive(1, 1, m_exp, 0, 0);
        drive(1, 1, (m_exp + 128) % 256, 0, 1);
        chk("clr err_cnt", 32'(cnt8), 32'd0);
        chk("clr err_pulse", 32'(pulse8), 32'd1);
        chk("clr state", 32'(st8), 32'd3);
        drive(1, 1, m_exp, 0, 0);
        chk("clr relock", 32'(locked8), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_checker.md
# count_checker

Receive-side checker for the free-running 8-bit counter stream driven by the counter block. Samples the count word on each enabled cycle and verifies that it steps by exactly ±1 modulo 2^WIDTH. Acquires lock after a run of consistent samples, then flags and counts every sequence break. Sits on the count output bus in the same clock domain as the counter.

## Interface
Parameters:
- WIDTH, 8, count word width.
- LOCK_CNT, 2, consecutive consistent samples, counting the first, needed to lock; legal range 2..15.
- ERRW, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge.
- enable  in  1  din is valid this cycle.
- din  in  WIDTH  count word under check.
- dir  in  1  expected step: 0 = +1 (up counter), 1 = −1 (down counter); sampled with each enabled din.
- locked  out  1  high while in LOCK.
- err_pulse  out  1  one-cycle pulse on a mismatch detected in LOCK.
- err_cnt  out  ERRW  saturating count of LOCK mismatches.
- expected  out  WIDTH  next value predicted.
- state  out  2  IDLE=00, ACQ=01, LOCK=10, ERR=11.

## Operation
- All outputs are registered. Internal match counter run is 4 bits.
- Prediction: next = din+1 when dir=0, din−1 when dir=1, truncated to WIDTH.
  - Wraps: 0xFF→0x00 and 0x00→0xFF at WIDTH=8.
- enable=0: every register holds except err_pulse, which clears to 0.
- IDLE: on an enabled sample, expected←next, run←1, go to ACQ.
- ACQ: on an enabled sample, always expected←next.
  - din==expected: run←run+1. If run+1==LOCK_CNT, go to LOCK.
  - Mismatch: run←1, stay in ACQ. Not counted as an error.
- LOCK: on an enabled sample, expected←next.
  - din==expected: stay in LOCK.
  - Mismatch: err_pulse←1, err_cnt←err_cnt+1 (holds at all-ones), go to ERR.
- ERR: on an enabled sample, expected←next.
  - din==expected: run←2. Go to LOCK if LOCK_CNT==2, else go to ACQ.
  - Mismatch: stay in ERR, no further count.
- Changing dir mid-stream is legal. The next compare uses the prediction made with the previous dir; the new dir takes effect from that sample's prediction.
- locked = (state==LOCK).

## Timing
- Reset (reset=0 at an edge) forces: state=IDLE, expected=0, run=0, locked=0, err_pulse=0, err_cnt=0.
- Reset mid-stream discards lock and error history at that edge.
- reset has priority over enable.
- A sample taken at edge N affects outputs visible after edge N (single-cycle latency).
- With LOCK_CNT=2, a clean stream gives locked=1 after the 2nd enabled sample.
- err_pulse is high for exactly the one cycle following the edge that detected the mismatch.
  - Back-to-back mismatches produce at most one pulse per LOCK exit.
- Saturation: at err_cnt = 2^ERRW−1, further mismatches still pulse err_pulse, but the count holds.

## Configuration
- CHECKER_ERR_CLR_EN defined:
  - Adds input port err_clr (1 bit).
  - err_clr=1 at an edge sets err_cnt←0.
  - If a mismatch occurs on the same edge, the clear wins: err_cnt=0, but err_pulse still asserts.
  - State and lock are unaffected.
- CHECKER_ERR_CLR_EN undefined:
  - No err_clr port.
  - err_cnt is cleared only by reset.

## Test plan
- Reset: hold reset=0 for 2 cycles with enable=1 and random din -> state=00, expected=0x00, err_cnt=0, locked=0.
- Up-count lock and wrap: dir=0, din=0xFD,0xFE,0xFF,0x00,0x01 -> locked=1 after 2nd sample, stays 1 across the wrap, err_cnt=0, expected=0x02 at the end.
- Down-count lock: dir=1, din=0x01,0x00,0xFF -> locked=1 after 2nd sample, expected=0xFE.
- Sequence break: locked on up-count at 0x10, then din=0x20, 0x21 -> err_pulse for one cycle, err_cnt=1, state=ERR; after 0x21, state=LOCK.
- Enable gaps and saturation: in LOCK, drop enable for 5 cycles -> all outputs hold. With ERRW=2, force 5 lock/break cycles -> err_cnt sticks at 3, five err_pulses seen.
- With CHECKER_ERR_CLR_EN: err_cnt=2, assert err_clr on the same edge as a LOCK mismatch -> err_cnt=0, err_pulse=1.
